// File: rtl/hfg_pkg.sv
// Shared widths, FSM encoding and saturation bounds for the cascade stage accumulator.
package hfg_pkg;

  localparam int HFG_VAL_W = 16;
  localparam int HFG_SUM_W = 24;
  localparam int HFG_CNT_W = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  localparam logic signed [HFG_SUM_W-1:0] SUM_MAX = {1'b0, {(HFG_SUM_W-1){1'b1}}};
  localparam logic signed [HFG_SUM_W-1:0] SUM_MIN = {1'b1, {(HFG_SUM_W-1){1'b0}}};

endpackage

// File: rtl/hfg_stage_accumulator_weak_select.sv
// Weak-classifier select: signed feature/threshold compare, vote mux, registered with valid.
module hfg_weak_select
  import hfg_pkg::*;
#(
  parameter int VAL_W = HFG_VAL_W,
  parameter int SUM_W = HFG_SUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    abort,
  input  logic                    in_vld,
  input  logic signed [31:0]      feature,
  input  logic signed [31:0]      weak_thr,
  input  logic signed [VAL_W-1:0] left_val,
  input  logic signed [VAL_W-1:0] right_val,
  input  logic                    last,
  input  logic signed [SUM_W-1:0] stage_thr,
  output logic                    vld_p1,
  output logic signed [VAL_W-1:0] vote_p1,
  output logic                    last_p1,
  output logic signed [SUM_W-1:0] stage_thr_p1
);

  always_ff @(posedge clk) begin
    if (!rst_n || abort) vld_p1 <= 1'b0;
    else                 vld_p1 <= in_vld;
  end

  // P1: data registers carry no reset; they are only observed while vld_p1 is set
  always_ff @(posedge clk) begin
    if (in_vld) begin
      vote_p1      <= (feature < weak_thr) ? left_val : right_val;
      last_p1      <= last;
      stage_thr_p1 <= stage_thr;
    end
  end

endmodule

// File: rtl/hfg_stage_accumulator.sv
// Cascade stage accumulator: sums weak votes and emits a pass/fail strobe on the last feature.
// Optional accumulator saturation is enabled by defining HFG_STAGE_SAT_EN.
module hfg_stage_accumulator
  import hfg_pkg::*;
#(
  parameter int VAL_W = HFG_VAL_W,
  parameter int SUM_W = HFG_SUM_W,
  parameter int CNT_W = HFG_CNT_W
) (
  input  logic                    iClk,
  input  logic                    iReset_n,
  input  logic                    iFeature_Valid,
  input  logic signed [31:0]      iFeature,
  input  logic signed [31:0]      iWeak_Thr,
  input  logic signed [VAL_W-1:0] iLeft_Val,
  input  logic signed [VAL_W-1:0] iRight_Val,
  input  logic                    iLast,
  input  logic signed [SUM_W-1:0] iStage_Thr,
  input  logic                    iAbort,
  output logic                    oBusy,
  output logic                    oStage_Valid,
  output logic                    oStage_Pass,
  output logic signed [SUM_W-1:0] oStage_Sum,
  output logic [CNT_W-1:0]        oFeature_Cnt,
  output logic                    oSat
);

  logic                    vld_p1;
  logic signed [VAL_W-1:0] vote_p1;
  logic                    last_p1;
  logic signed [SUM_W-1:0] stage_thr_p1;

  state_t                  state, state_nxt;
  logic signed [SUM_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic signed [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0]        cnt_next;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  hfg_weak_select #(
    .VAL_W(VAL_W),
    .SUM_W(SUM_W)
  ) u_weak_select (
    .clk         (iClk),
    .rst_n       (iReset_n),
    .abort       (iAbort),
    .in_vld      (iFeature_Valid),
    .feature     (iFeature),
    .weak_thr    (iWeak_Thr),
    .left_val    (iLeft_Val),
    .right_val   (iRight_Val),
    .last        (iLast),
    .stage_thr   (iStage_Thr),
    .vld_p1      (vld_p1),
    .vote_p1     (vote_p1),
    .last_p1     (last_p1),
    .stage_thr_p1(stage_thr_p1)
  );

`ifdef HFG_STAGE_SAT_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  logic signed [SUM_W:0] sum_wide;
  logic                  clamp_now;
  logic                  sat_flag;
  logic                  sat_out;

  function automatic logic overflows(input logic signed [SUM_W:0] w);
    return w[SUM_W] != w[SUM_W-1];
  endfunction

  function automatic logic signed [SUM_W-1:0] sat_sum(input logic signed [SUM_W:0] w);
    if (!overflows(w)) return w[SUM_W-1:0];
    return w[SUM_W] ? SAT_MIN : SAT_MAX;
  endfunction

  assign sum_wide  = (SUM_W+1)'(acc) + (SUM_W+1)'(vote_p1);
  assign sum_next  = sat_sum(sum_wide);
  assign clamp_now = overflows(sum_wide);

  // Sticky clamp flag for the stage in progress, reported alongside the strobe
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      sat_flag <= 1'b0;
      sat_out  <= 1'b0;
    end else if (iAbort) begin
      sat_flag <= 1'b0;
    end else if (vld_p1) begin
      if (last_p1) begin
        sat_out  <= sat_flag | clamp_now;
        sat_flag <= 1'b0;
      end else begin
        sat_flag <= sat_flag | clamp_now;
      end
    end
  end

  assign oSat = sat_out;
`else
  assign sum_next = acc + SUM_W'(vote_p1);
  assign oSat     = 1'b0;
`endif

  assign cnt_next = cnt_inc(cnt);
  assign oBusy    = vld_p1 || (state == S_ACC);

  always_comb begin
    state_nxt = state;
    if (iAbort)      state_nxt = S_IDLE;
    else if (vld_p1) state_nxt = last_p1 ? S_IDLE : S_ACC;
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // P2: accumulate, or close the stage and publish the result
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      acc          <= '0;
      cnt          <= '0;
      oStage_Valid <= 1'b0;
      oStage_Pass  <= 1'b0;
      oStage_Sum   <= '0;
      oFeature_Cnt <= '0;
    end else begin
      oStage_Valid <= 1'b0;
      if (iAbort) begin
        acc <= '0;
        cnt <= '0;
      end else if (vld_p1) begin
        if (last_p1) begin
          oStage_Sum   <= sum_next;
          oStage_Pass  <= (sum_next >= stage_thr_p1);
          oFeature_Cnt <= cnt_next;
          oStage_Valid <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
        end else begin
          acc <= sum_next;
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_hfg_stage_accumulator.sv
// Scoreboard bench: a default-width instance and a narrow instance (SUM_W=8, CNT_W=2).
module tb_hfg_stage_accumulator;

  typedef struct {
    int sum;
    int pass;
    int cnt;
    int sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               a_fv, a_last, a_abort;
  logic signed [31:0] a_feat, a_wthr;
  logic signed [15:0] a_lv, a_rv;
  logic signed [23:0] a_sthr;
  logic               a_busy, a_valid, a_pass, a_sat;
  logic signed [23:0] a_sum;
  logic [9:0]         a_cnt;

  logic               b_fv, b_last, b_abort;
  logic signed [31:0] b_feat, b_wthr;
  logic signed [7:0]  b_lv, b_rv;
  logic signed [7:0]  b_sthr;
  logic               b_busy, b_valid, b_pass, b_sat;
  logic signed [7:0]  b_sum;
  logic [1:0]         b_cnt;

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  hfg_stage_accumulator dut_a (
    .iClk(clk), .iReset_n(rst_n), .iFeature_Valid(a_fv), .iFeature(a_feat),
    .iWeak_Thr(a_wthr), .iLeft_Val(a_lv), .iRight_Val(a_rv), .iLast(a_last),
    .iStage_Thr(a_sthr), .iAbort(a_abort), .oBusy(a_busy), .oStage_Valid(a_valid),
    .oStage_Pass(a_pass), .oStage_Sum(a_sum), .oFeature_Cnt(a_cnt), .oSat(a_sat)
  );

  hfg_stage_accumulator #(.VAL_W(8), .SUM_W(8), .CNT_W(2)) dut_b (
    .iClk(clk), .iReset_n(rst_n), .iFeature_Valid(b_fv), .iFeature(b_feat),
    .iWeak_Thr(b_wthr), .iLeft_Val(b_lv), .iRight_Val(b_rv), .iLast(b_last),
    .iStage_Thr(b_sthr), .iAbort(b_abort), .oBusy(b_busy), .oStage_Valid(b_valid),
    .oStage_Pass(b_pass), .oStage_Sum(b_sum), .oFeature_Cnt(b_cnt), .oSat(b_sat)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a strobe is presented
  always @(negedge clk) begin
    if (a_valid) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_strobe got sum=%0d expected no strobe", int'(a_sum));
      end else begin
        ea = qa.pop_front();
        chk("a_sum", int'(a_sum), ea.sum);
        chk("a_pass", int'(a_pass), ea.pass);
        chk("a_cnt", int'(a_cnt), ea.cnt);
        chk("a_sat", int'(a_sat), ea.sat);
      end
    end
    if (b_valid) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_strobe got sum=%0d expected no strobe", int'(b_sum));
      end else begin
        eb = qb.pop_front();
        chk("b_sum", int'(b_sum), eb.sum);
        chk("b_pass", int'(b_pass), eb.pass);
        chk("b_cnt", int'(b_cnt), eb.cnt);
        chk("b_sat", int'(b_sat), eb.sat);
      end
    end
  end

  task automatic feat(input bit sel, input int f, input int thr, input int lv, input int rv,
                      input bit last, input int sthr, input bit abort);
    if (!sel) begin
      a_fv = 1'b1; a_feat = f; a_wthr = thr; a_lv = 16'(lv); a_rv = 16'(rv);
      a_last = last; a_sthr = 24'(sthr); a_abort = abort;
    end else begin
      b_fv = 1'b1; b_feat = f; b_wthr = thr; b_lv = 8'(lv); b_rv = 8'(rv);
      b_last = last; b_sthr = 8'(sthr); b_abort = abort;
    end
    @(posedge clk); #1;
    a_fv = 1'b0; a_last = 1'b0; a_abort = 1'b0;
    b_fv = 1'b0; b_last = 1'b0; b_abort = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input bit sel, input int sum, input int pass, input int cnt, input int sat);
    exp_t e;
    e.sum = sum; e.pass = pass; e.cnt = cnt; e.sat = sat;
    if (!sel) qa.push_back(e);
    else      qb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_valid"}, int'(a_valid), 0);
    chk({tag, "_a_pass"}, int'(a_pass), 0);
    chk({tag, "_a_sum"}, int'(a_sum), 0);
    chk({tag, "_a_cnt"}, int'(a_cnt), 0);
    chk({tag, "_a_sat"}, int'(a_sat), 0);
    chk({tag, "_a_busy"}, int'(a_busy), 0);
    chk({tag, "_b_valid"}, int'(b_valid), 0);
    chk({tag, "_b_sum"}, int'(b_sum), 0);
    chk({tag, "_b_busy"}, int'(b_busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_fv = 0; a_feat = 0; a_wthr = 0; a_lv = 0; a_rv = 0; a_last = 0; a_sthr = 0; a_abort = 0;
    b_fv = 0; b_feat = 0; b_wthr = 0; b_lv = 0; b_rv = 0; b_last = 0; b_sthr = 0; b_abort = 0;
    idle(3);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Three features, votes +30, -10, +30 -> 50 against thr 40
    feat(0, 1000, 500, -10, 30, 0, 0, 0);
    chk("busy_during_stage", int'(a_busy), 1);
    feat(0, 200, 500, -10, 30, 0, 0, 0);
    push(0, 50, 1, 3, 0);
    feat(0, -5, -5, -10, 30, 1, 40, 0);
    chk("latency_not_early", int'(a_valid), 0);
    idle(1);
    chk("latency_strobe", int'(a_valid), 1);
    idle(1);
    chk("strobe_one_cycle", int'(a_valid), 0);
    chk("busy_after_stage", int'(a_busy), 0);

    // Same votes against thr 51
    feat(0, 1000, 500, -10, 30, 0, 0, 0);
    feat(0, 200, 500, -10, 30, 0, 0, 0);
    push(0, 50, 0, 3, 0);
    feat(0, -5, -5, -10, 30, 1, 51, 0);
    idle(3);

    // Back-to-back stages with no gap
    push(0, 20, 1, 2, 0);
    push(0, -7, 0, 1, 0);
    feat(0, 1, 0, -3, 10, 0, 0, 0);
    feat(0, 1, 0, -3, 10, 1, 20, 0);
    feat(0, -1, 0, -7, 9, 1, 0, 0);
    idle(3);

    // Abort on the second feature, then a fresh one-feature stage
    feat(0, 5, 0, -1, 100, 0, 0, 0);
    feat(0, 5, 0, -1, 100, 0, 0, 1);
    chk("busy_after_abort", int'(a_busy), 0);
    push(0, 5, 1, 1, 0);
    feat(0, 0, 0, -2, 5, 1, 0, 0);
    idle(3);

    // Abort while P1 holds a last feature: strobe suppressed, results held
    feat(0, 0, 0, 0, 9, 1, 0, 0);
    a_abort = 1'b1;
    idle(1);
    a_abort = 1'b0;
    idle(2);
    chk("held_sum", int'(a_sum), 5);
    chk("held_cnt", int'(a_cnt), 1);
    chk("held_pass", int'(a_pass), 1);

    // Narrow instance: overflow, sat flag clearing, counter saturation
`ifdef HFG_STAGE_SAT_EN
    push(1, 127, 1, 2, 1);
`else
    push(1, -56, 0, 2, 0);
`endif
    feat(1, 0, 0, 0, 100, 0, 0, 0);
    feat(1, 0, 0, 0, 100, 1, 0, 0);
    push(1, 1, 1, 1, 0);
    feat(1, 0, 0, 0, 1, 1, 0, 0);
    push(1, 0, 1, 3, 0);
    for (int i = 0; i < 5; i++) feat(1, 0, 0, 0, 0, (i == 4), 0, 0);
    idle(3);

    // Reset while P1 holds a last feature
    feat(0, 0, 0, 0, 3, 1, 0, 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk_zero("reset_midstage");
    idle(3);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
